// File: rtl/arp_frame_tx.sv
// Byte-serial Ethernet II ARP request/reply transmitter on the GMII transmit path.
// Define ARP_TX_FCS_EN to append the CRC-32 FCS; otherwise the frame ends after the pad.
module arp_frame_tx #(
    parameter logic [47:0] BOARD_MAC  = 48'h00_11_22_33_44_55,
    parameter logic [31:0] BOARD_IP   = {8'd192, 8'd168, 8'd1, 8'd10},
    parameter int unsigned IFG_CYCLES = 12
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        arp_tx_en_i,
    input  logic        arp_tx_type_i,
    input  logic [47:0] des_mac_i,
    input  logic [31:0] des_ip_i,
    output logic        gmii_tx_dv_o,
    output logic [7:0]  gmii_tx_data_o,
    output logic        arp_tx_busy_o,
    output logic        arp_tx_done_o
);

    typedef enum logic [2:0] {
        StIdle,
        StPreamble,
        StHeader,
        StArp,
        StPad,
`ifdef ARP_TX_FCS_EN
        StFcs,
`endif
        StGap
    } state_e;

    localparam logic [6:0] GapLast = 7'(IFG_CYCLES - 1);

    state_e      state_q, state_d;
    logic [6:0]  cnt_q, cnt_d;
    logic        type_q, type_d;
    logic [47:0] mac_q, mac_d;
    logic [31:0] ip_q, ip_d;
    logic        dv_q, dv_d;
    logic [7:0]  data_q, data_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic [47:0]  da, tha;
    logic [15:0]  oper;
    logic [111:0] hdr_vec;
    logic [223:0] arp_vec;
    logic [7:0]   hdr_byte, arp_byte;

`ifdef ARP_TX_FCS_EN
    logic [31:0] crc_q, crc_d;
    logic [7:0]  fcs_byte;

    // Reflected CRC-32, one byte per cycle, LSB of the byte first.
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] b);
        logic [31:0] c;
        c = crc ^ {24'h0, b};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        end
        return c;
    endfunction

    always_comb begin
        fcs_byte = 8'(~crc_q >> {cnt_q[1:0], 3'b000});
    end
`endif

    // Frame fields as flat vectors, MSB byte first; the counter picks the byte.
    always_comb begin
        da       = type_q ? mac_q : 48'hFFFF_FFFF_FFFF;
        tha      = type_q ? mac_q : 48'h0;
        oper     = type_q ? 16'h0002 : 16'h0001;
        hdr_vec  = {da, BOARD_MAC, 16'h0806};
        arp_vec  = {16'h0001, 16'h0800, 8'h06, 8'h04, oper, BOARD_MAC, BOARD_IP, tha, ip_q};
        hdr_byte = 8'(hdr_vec >> (8 * (7'd13 - cnt_q)));
        arp_byte = 8'(arp_vec >> (8 * (7'd27 - cnt_q)));
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 7'd1;
        type_d  = type_q;
        mac_d   = mac_q;
        ip_d    = ip_q;
        dv_d    = 1'b0;
        data_d  = 8'h00;
        done_d  = 1'b0;
        busy_d  = (state_q != StIdle);
`ifdef ARP_TX_FCS_EN
        crc_d   = crc_q;
`endif
        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
`ifdef ARP_TX_FCS_EN
                crc_d = '1;
`endif
                if (arp_tx_en_i) begin
                    type_d  = arp_tx_type_i;
                    mac_d   = des_mac_i;
                    ip_d    = des_ip_i;
                    state_d = StPreamble;
                end
            end
            StPreamble: begin
                dv_d   = 1'b1;
                data_d = (cnt_q == 7'd7) ? 8'hD5 : 8'h55;
                if (cnt_q == 7'd7) begin
                    state_d = StHeader;
                    cnt_d   = '0;
                end
            end
            StHeader: begin
                dv_d   = 1'b1;
                data_d = hdr_byte;
`ifdef ARP_TX_FCS_EN
                crc_d  = crc32_byte(crc_q, hdr_byte);
`endif
                if (cnt_q == 7'd13) begin
                    state_d = StArp;
                    cnt_d   = '0;
                end
            end
            StArp: begin
                dv_d   = 1'b1;
                data_d = arp_byte;
`ifdef ARP_TX_FCS_EN
                crc_d  = crc32_byte(crc_q, arp_byte);
`endif
                if (cnt_q == 7'd27) begin
                    state_d = StPad;
                    cnt_d   = '0;
                end
            end
            StPad: begin
                dv_d = 1'b1;
`ifdef ARP_TX_FCS_EN
                crc_d = crc32_byte(crc_q, 8'h00);
`endif
                if (cnt_q == 7'd17) begin
`ifdef ARP_TX_FCS_EN
                    state_d = StFcs;
`else
                    state_d = StGap;
`endif
                    cnt_d   = '0;
                end
            end
`ifdef ARP_TX_FCS_EN
            StFcs: begin
                dv_d   = 1'b1;
                data_d = fcs_byte;
                if (cnt_q == 7'd3) begin
                    state_d = StGap;
                    cnt_d   = '0;
                end
            end
`endif
            StGap: begin
                done_d = (cnt_q == 7'd0);
                if (cnt_q == GapLast) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            type_q  <= 1'b0;
            mac_q   <= '0;
            ip_q    <= '0;
            dv_q    <= 1'b0;
            data_q  <= 8'h00;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef ARP_TX_FCS_EN
            crc_q   <= '1;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            type_q  <= type_d;
            mac_q   <= mac_d;
            ip_q    <= ip_d;
            dv_q    <= dv_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef ARP_TX_FCS_EN
            crc_q   <= crc_d;
`endif
        end
    end

    assign gmii_tx_dv_o   = dv_q;
    assign gmii_tx_data_o = data_q;
    assign arp_tx_busy_o  = busy_q;
    assign arp_tx_done_o  = done_q;

endmodule

// File: tb/tb_arp_frame_tx.sv
// Directed bench for arp_frame_tx: frame contents, timing, busy drop, reset truncation.
// Honours ARP_TX_FCS_EN the same way as the design (72 B with FCS, 68 B without).
module tb_arp_frame_tx;

`ifdef ARP_TX_FCS_EN
    localparam int FrameLen = 72;
`else
    localparam int FrameLen = 68;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        typ;
    logic [47:0] des_mac;
    logic [31:0] des_ip;
    logic        dv;
    logic [7:0]  data;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    logic [7:0] frame [0:127];
    int         flen;
    logic       done_end;

    arp_frame_tx dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .arp_tx_en_i   (en),
        .arp_tx_type_i (typ),
        .des_mac_i     (des_mac),
        .des_ip_i      (des_ip),
        .gmii_tx_dv_o  (dv),
        .gmii_tx_data_o(data),
        .arp_tx_busy_o (busy),
        .arp_tx_done_o (done)
    );

    always #4 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] fld(input int first, input int n);
        logic [63:0] v;
        v = '0;
        for (int i = 0; i < n; i++) v = {v[55:0], frame[first+i]};
        return v;
    endfunction

    // Receiver-side CRC over DA..FCS, reported in MSB-first bit order.
    function automatic logic [31:0] residue(input int first, input int last);
        logic [31:0] c;
        logic [31:0] r;
        c = '1;
        for (int i = first; i <= last; i++) begin
            c = c ^ {24'h0, frame[i]};
            for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        end
        for (int k = 0; k < 32; k++) r[k] = c[31-k];
        return r;
    endfunction

    // Records dv bytes from the current sample on; returns at the first dv=0 sample.
    task automatic capture();
        int guard;
        guard = 0;
        while (dv !== 1'b1 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        flen = 0;
        while (dv === 1'b1 && flen < 128) begin
            frame[flen] = data;
            flen++;
            @(negedge clk);
        end
        done_end = done;
    endtask

    // Called on the done sample: done must be a single pulse, busy falls 12 cycles later.
    task automatic wait_idle(input string tag);
        int   k;
        logic dv_seen;
        k       = 0;
        dv_seen = 1'b0;
        while (busy === 1'b1 && k < 40) begin
            @(negedge clk);
            k++;
            if (k == 1) chk({tag, "_done_pulse"}, 64'(done), 64'd0);
            if (dv !== 1'b0) dv_seen = 1'b1;
        end
        chk({tag, "_busy_fall"}, 64'(k), 64'd12);
        chk({tag, "_gap_dv"}, 64'(dv_seen), 64'd0);
    endtask

    task automatic check_frame(input string tag, input logic [47:0] exp_da,
                               input logic [15:0] exp_oper, input logic [47:0] exp_tha,
                               input logic [31:0] exp_tpa);
        chk({tag, "_len"}, 64'(flen), 64'(FrameLen));
        chk({tag, "_preamble"}, fld(0, 8), 64'h5555_5555_5555_55D5);
        chk({tag, "_da"}, fld(8, 6), 64'(exp_da));
        chk({tag, "_sa"}, fld(14, 6), 64'h0011_2233_4455);
        chk({tag, "_ethertype"}, fld(20, 2), 64'h0806);
        chk({tag, "_htype_plen"}, fld(22, 6), 64'h0001_0800_0604);
        chk({tag, "_oper"}, fld(28, 2), 64'(exp_oper));
        chk({tag, "_sha"}, fld(30, 6), 64'h0011_2233_4455);
        chk({tag, "_spa"}, fld(36, 4), 64'hC0A8_010A);
        chk({tag, "_tha"}, fld(40, 6), 64'(exp_tha));
        chk({tag, "_tpa"}, fld(46, 4), 64'(exp_tpa));
        chk({tag, "_pad"}, fld(50, 8) | fld(58, 8) | fld(66, 2), 64'h0);
        chk({tag, "_done"}, 64'(done_end), 64'd1);
`ifdef ARP_TX_FCS_EN
        chk({tag, "_residue"}, 64'(residue(8, 71)), 64'hC704_DD7B);
`endif
    endtask

    initial begin
        logic dv_bad;
        logic done_bad;

        rst_n   = 1'b0;
        en      = 1'b0;
        typ     = 1'b0;
        des_mac = 48'h1234_5678_9ABC;
        des_ip  = 32'hC0A8_0166;
        repeat (3) @(negedge clk);
        chk("reset_dv", 64'(dv), 64'd0);
        chk("reset_data", 64'(data), 64'h00);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Request: DA broadcast and THA zero even though des_mac is non-zero.
        en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        chk("a_lat_dv", 64'(dv), 64'd0);
        chk("a_lat_busy", 64'(busy), 64'd0);
        @(negedge clk);
        chk("a_first_dv", 64'(dv), 64'd1);
        chk("a_first_busy", 64'(busy), 64'd1);
        chk("a_first_data", 64'(data), 64'h55);
        capture();
        check_frame("a", 48'hFFFF_FFFF_FFFF, 16'h0001, 48'h0, 32'hC0A8_0166);
        wait_idle("a");

        // Reply.
        typ     = 1'b1;
        des_mac = 48'hA0B1_C2D3_E4F5;
        en      = 1'b1;
        @(negedge clk);
        en = 1'b0;
        capture();
        check_frame("b", 48'hA0B1_C2D3_E4F5, 16'h0002, 48'hA0B1_C2D3_E4F5, 32'hC0A8_0166);
        wait_idle("b");

        // Second start while busy is dropped; inputs changed mid-frame are ignored.
        typ     = 1'b0;
        des_mac = 48'h0;
        des_ip  = 32'hC0A8_0107;
        en      = 1'b1;
        @(negedge clk);
        en = 1'b0;
        fork
            capture();
            begin
                repeat (10) @(negedge clk);
                en      = 1'b1;
                typ     = 1'b1;
                des_mac = 48'h0102_0304_0506;
                des_ip  = 32'hC0A8_01EE;
                @(negedge clk);
                en = 1'b0;
            end
        join
        check_frame("c", 48'hFFFF_FFFF_FFFF, 16'h0001, 48'h0, 32'hC0A8_0107);

        // Start held high through the gap: taken on the edge busy falls, so dv is low
        // for the 12 gap cycles plus that acceptance cycle.
        typ    = 1'b0;
        des_ip = 32'hC0A8_0144;
        en     = 1'b1;
        wait_idle("c");
        chk("d_idle_dv", 64'(dv), 64'd0);
        @(negedge clk);
        chk("d_held_start_dv", 64'(dv), 64'd1);
        chk("d_held_start_data", 64'(data), 64'h55);
        en = 1'b0;
        capture();
        check_frame("d", 48'hFFFF_FFFF_FFFF, 16'h0001, 48'h0, 32'hC0A8_0144);
        wait_idle("d");

        // Reset at byte 30, with a start asserted during reset.
        des_ip = 32'hC0A8_0133;
        en     = 1'b1;
        @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        repeat (30) @(negedge clk);
        chk("e_byte30_dv", 64'(dv), 64'd1);
        chk("e_byte30_data", 64'(data), 64'h00);
        rst_n = 1'b0;
        en    = 1'b1;
        @(negedge clk);
        chk("e_trunc_dv", 64'(dv), 64'd0);
        chk("e_trunc_busy", 64'(busy), 64'd0);
        chk("e_trunc_done", 64'(done), 64'd0);
        @(negedge clk);
        rst_n    = 1'b1;
        en       = 1'b0;
        dv_bad   = 1'b0;
        done_bad = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (dv !== 1'b0) dv_bad = 1'b1;
            if (done !== 1'b0) done_bad = 1'b1;
        end
        chk("e_post_reset_dv", 64'(dv_bad), 64'd0);
        chk("e_post_reset_done", 64'(done_bad), 64'd0);

        typ     = 1'b1;
        des_mac = 48'hA0B1_C2D3_E4F5;
        en      = 1'b1;
        @(negedge clk);
        en = 1'b0;
        capture();
        check_frame("e", 48'hA0B1_C2D3_E4F5, 16'h0002, 48'hA0B1_C2D3_E4F5, 32'hC0A8_0133);
        wait_idle("e");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
